// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, pairs each 1-cycle-latency imem word with its address,
// handles redirect/hold in step with the memory, traps bad addresses into HALT and counts events.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_jump,
  input  logic [31:0] jump_target,
  input  logic        is_stoll,
  output logic [31:0] pc,
  input  logic [31:0] imem_inst,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  localparam logic [1:0] CauseNone     = 2'd0;
  localparam logic [1:0] CauseMisalign = 2'd1;
  localparam logic [1:0] CauseRange    = 2'd2;
  localparam logic [1:0] CauseOverrun  = 2'd3;

  // One past the last legal byte address; 33 bits so a 32-bit address never wraps past it.
  localparam logic [32:0] AddrLimit = 33'd1 << (ADDR_WIDTH + 2);

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic [31:0] pc_next;
  logic        seq_overrun;
  logic        tgt_misaligned;
  logic        tgt_out_of_range;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    pc_next          = pc_q + 32'd4;
    seq_overrun      = ({1'b0, pc_q} + 33'd4) >= AddrLimit;
    tgt_misaligned   = |jump_target[1:0];
    tgt_out_of_range = {1'b0, jump_target} >= AddrLimit;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_pc_d      = id_pc_q;
    id_valid_d   = id_valid_q;
    cause_d      = cause_q;
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;

    unique case (state_q)
      StRun: begin
        if (is_jump) begin
          // The memory zeroes its output on a jump, so the next slot is always a bubble.
          id_valid_d   = 1'b0;
          bubble_cnt_d = sat_inc(bubble_cnt_q);
          if (tgt_misaligned) begin
            state_d = StHalt;
            cause_d = CauseMisalign;
          end else if (tgt_out_of_range) begin
            state_d = StHalt;
            cause_d = CauseRange;
          end else begin
            pc_d = jump_target;
          end
        end else if (is_stoll) begin
          stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
          id_pc_d     = pc_q;
          id_valid_d  = 1'b1;
          fetch_cnt_d = sat_inc(fetch_cnt_q);
          // Last word is still delivered; the PC stays on it.
          if (seq_overrun) begin
            state_d = StHalt;
            cause_d = CauseOverrun;
          end else begin
            pc_d = pc_next;
          end
        end
      end
      StHalt: begin
        id_valid_d = 1'b0;
      end
      default: begin
        state_d    = StHalt;
        id_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      id_pc_q      <= 32'd0;
      id_valid_q   <= 1'b0;
      cause_q      <= CauseNone;
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
      stall_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_pc_q      <= id_pc_d;
      id_valid_q   <= id_valid_d;
      cause_q      <= cause_d;
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign pc         = pc_q;
  assign id_pc      = id_pc_q;
  assign id_valid   = id_valid_q;
  assign id_inst    = id_valid_q ? imem_inst : NOP_INST;
  assign halted     = (state_q == StHalt);
  assign halt_cause = cause_q;
  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a behavioural fetch model predicts every cycle's outputs,
// a monitor compares them against the DUT driving a 1-cycle-latency instruction memory.
module tb_inst_fetch;

  localparam int unsigned AW      = 6;
  localparam longint      LIMIT   = 4 * (longint'(1) << AW);
  localparam int          NWORDS  = 1 << AW;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        is_stoll = 1'b0;
  logic [31:0] pc;
  logic [31:0] imem_inst = 32'd0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] stall_cnt;

  inst_fetch #(
    .RESET_PC  (RST_PC),
    .ADDR_WIDTH(AW),
    .NOP_INST  (NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .is_jump    (is_jump),
    .jump_target(jump_target),
    .is_stoll   (is_stoll),
    .pc         (pc),
    .imem_inst  (imem_inst),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_valid   (id_valid),
    .halted     (halted),
    .halt_cause (halt_cause),
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous imem: zero on jump, hold on stall, otherwise read the presented word.
  logic [31:0] mem [NWORDS];
  always @(posedge clk) begin
    if (is_jump) imem_inst <= 32'd0;
    else if (!is_stoll) imem_inst <= mem[pc[AW+1:2]];
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        halted;
    logic [1:0]  cause;
    logic [31:0] fc;
    logic [31:0] bc;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  longint m_pc, m_id_pc;
  bit     m_valid, m_halted;
  int     m_cause;
  longint m_fc, m_bc, m_sc;

  function automatic longint sat(input longint v);
    return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
  endfunction

  task automatic model_step(input bit r, input bit j, input longint t, input bit s);
    exp_t e;
    if (!r) begin
      m_pc = RST_PC; m_id_pc = 0; m_valid = 0; m_halted = 0; m_cause = 0;
      m_fc = 0; m_bc = 0; m_sc = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (j) begin
      m_bc = sat(m_bc);
      m_valid = 0;
      if (t % 4 != 0) begin m_halted = 1; m_cause = 1; end
      else if (t >= LIMIT) begin m_halted = 1; m_cause = 2; end
      else m_pc = t;
    end else if (s) begin
      m_sc = sat(m_sc);
    end else begin
      m_id_pc = m_pc;
      m_valid = 1;
      m_fc = sat(m_fc);
      if (m_pc + 4 >= LIMIT) begin m_halted = 1; m_cause = 3; end
      else m_pc = m_pc + 4;
    end
    e.pc       = 32'(m_pc);
    e.id_pc    = 32'(m_id_pc);
    e.id_valid = m_valid;
    e.id_inst  = m_valid ? mem[int'(m_id_pc / 4)] : NOP;
    e.halted   = m_halted;
    e.cause    = 2'(m_cause);
    e.fc       = 32'(m_fc);
    e.bc       = 32'(m_bc);
    e.sc       = 32'(m_sc);
    exp_q.push_back(e);
  endtask

  // Inputs change 2 time units after an edge; the prediction is for the following edge.
  task automatic drive(input bit r, input bit j, input logic [31:0] t, input bit s);
    @(posedge clk);
    #2;
    rst_n = r; is_jump = j; jump_target = t; is_stoll = s;
    model_step(r, j, longint'(t), s);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: one prediction per edge, compared 1 time unit after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("id_valid", {31'd0, id_valid}, {31'd0, e.id_valid});
        chk("id_pc", id_pc, e.id_pc);
        chk("id_inst", id_inst, e.id_inst);
        chk("halted", {31'd0, halted}, {31'd0, e.halted});
        chk("halt_cause", {30'd0, halt_cause}, {30'd0, e.cause});
        chk("fetch_cnt", fetch_cnt, e.fc);
        chk("bubble_cnt", bubble_cnt, e.bc);
        chk("stall_cnt", stall_cnt, e.sc);
      end
    end
  end

  initial begin
    for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
    mem[0] = 32'hAAAA_0001;
    mem[1] = 32'hBBBB_0002;
    mem[2] = 32'hCCCC_0003;

    do_reset();
    run(4);
    drive(1'b1, 1'b1, 32'h40, 1'b0);
    run(3);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'd0, 1'b1);
    run(2);
    drive(1'b1, 1'b1, 32'h80, 1'b1);
    drive(1'b1, 1'b1, 32'h20, 1'b0);
    drive(1'b1, 1'b1, 32'h24, 1'b0);
    run(3);
    drive(1'b1, 1'b1, 32'h42, 1'b0);
    drive(1'b1, 1'b1, 32'h10, 1'b0);
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    run(2);

    do_reset();
    run(NWORDS + 4);

    do_reset();
    drive(1'b1, 1'b1, 32'h100, 1'b0);
    run(2);
    do_reset();
    drive(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run(2);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      int          k;
      k = int'($urandom_range(0, 99));
      t = 32'($urandom_range(0, NWORDS - 1)) << 2;
      if (k < 2) t = t | 32'd2;
      else if (k < 4) t = t + 32'(LIMIT);
      if (m_halted && ($urandom_range(0, 3) == 0)) drive(1'b0, 1'b0, 32'd0, 1'b0);
      else drive(1'b1, $urandom_range(0, 7) == 0, t, $urandom_range(0, 3) == 0);
    end

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
